// File: rtl/tug_pkg.sv
// Shared definitions for the tug-of-war design: key polarity, default debounce
// window and the debounced key state type used by input and scoring logic.
package tug_pkg;

    localparam logic KEY_ACTIVE_LEVEL        = 1'b0;
    localparam int   DEFAULT_DEBOUNCE_CYCLES = 1000000;

    typedef enum logic {
        KEY_RELEASED = 1'b0,
        KEY_PRESSED  = 1'b1
    } key_state_t;

endpackage

// File: rtl/key_debounce_channel.sv
// One push-button channel: 2-FF synchroniser, stability counter, debounced
// state and a single-cycle pulse on each accepted press.
module key_debounce_channel
    import tug_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press,
    output logic held
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    key_state_t       r_state;
    key_state_t       w_state_nxt;
    key_state_t       w_sampled;
    logic             r_press;
    logic             w_press_nxt;
    logic             r_held;

    // Reset value 1 means "released", so a key held through reset is re-seen as a new press.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_sampled   = (r_sync2 == KEY_ACTIVE_LEVEL) ? KEY_PRESSED : KEY_RELEASED;
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_press_nxt = 1'b0;
        if (w_sampled != r_state) begin
            if (r_cnt == CNT_LAST) begin
                w_state_nxt = w_sampled;
                w_press_nxt = (w_sampled == KEY_PRESSED);
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= KEY_RELEASED;
            r_cnt   <= '0;
            r_press <= 1'b0;
            r_held  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_press <= w_press_nxt;
            r_held  <= (w_state_nxt == KEY_PRESSED);
        end
    end

    assign press = r_press;
    assign held  = r_held;

endmodule

// File: rtl/key_press_conditioner.sv
// Player key front end: two independent debounce channels turning raw
// active-low buttons into press pulses and debounced held levels.
module key_press_conditioner
    import tug_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic key_l_n,
    input  logic key_r_n,
    output logic l_press,
    output logic r_press,
    output logic l_held,
    output logic r_held
);

    key_debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_left (
        .clk   (clk),
        .reset (reset),
        .key_n (key_l_n),
        .press (l_press),
        .held  (l_held)
    );

    key_debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_right (
        .clk   (clk),
        .reset (reset),
        .key_n (key_r_n),
        .press (r_press),
        .held  (r_held)
    );

endmodule

// File: tb/tb_key_press_conditioner.sv
// Scoreboard bench for key_press_conditioner: directed scenarios followed by
// random key activity, checked every cycle against a run-length reference model.
module tb_key_press_conditioner;

    localparam int DC = 4;

    logic clk = 1'b0;
    logic reset;
    logic key_l_n;
    logic key_r_n;
    logic l_press;
    logic r_press;
    logic l_held;
    logic r_held;

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    bit started = 1'b0;

    logic [3:0] exp_q[$];

    key_press_conditioner #(
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .key_l_n (key_l_n),
        .key_r_n (key_r_n),
        .l_press (l_press),
        .r_press (r_press),
        .l_held  (l_held),
        .r_held  (r_held)
    );

    always #5 clk = ~clk;

    // Reference model: a key level is accepted once the synchronised input
    // (raw input two samples late) has shown the new value for DC samples in a row.
    bit m_s1[2];
    bit m_s2[2];
    bit m_prev[2];
    int m_run[2];
    bit m_pressed[2];

    always @(posedge clk) begin
        bit raw;
        bit v;
        bit ep[2];
        bit eh[2];
        cycle++;
        for (int ch = 0; ch < 2; ch++) begin
            raw = (ch == 0) ? key_l_n : key_r_n;
            ep[ch] = 1'b0;
            if (reset) begin
                m_s1[ch]      = 1'b1;
                m_s2[ch]      = 1'b1;
                m_prev[ch]    = 1'b1;
                m_run[ch]     = 0;
                m_pressed[ch] = 1'b0;
            end else begin
                v        = m_s2[ch];
                m_s2[ch] = m_s1[ch];
                m_s1[ch] = raw;
                m_run[ch] = (v == m_prev[ch]) ? m_run[ch] + 1 : 1;
                if (m_run[ch] > 1000) m_run[ch] = 1000;
                m_prev[ch] = v;
                if ((v == 1'b0) != m_pressed[ch] && m_run[ch] >= DC) begin
                    m_pressed[ch] = (v == 1'b0);
                    ep[ch]        = m_pressed[ch];
                end
            end
            eh[ch] = m_pressed[ch];
        end
        exp_q.push_back({ep[0], eh[0], ep[1], eh[1]});
        started = 1'b1;
    end

    always @(negedge clk) begin
        logic [3:0] e;
        logic [3:0] act;
        if (started) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL scoreboard_empty cycle %0d: no expected entry available", cycle);
            end else begin
                e   = exp_q.pop_front();
                act = {l_press, l_held, r_press, r_held};
                if (act !== e) begin
                    fails++;
                    $display("FAIL outputs cycle %0d: got {l_press,l_held,r_press,r_held}=%b, expected %b",
                             cycle, act, e);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        reset   = 1'b1;
        key_l_n = 1'b1;
        key_r_n = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(10);

        // Left press held long, then glitches on the right of 2 and 3 cycles.
        key_l_n = 1'b0;
        cyc(20);
        key_r_n = 1'b0; cyc(2); key_r_n = 1'b1; cyc(10);
        key_r_n = 1'b0; cyc(3); key_r_n = 1'b1; cyc(10);

        // Release, then a second press.
        key_l_n = 1'b1;
        cyc(10);
        key_l_n = 1'b0;
        cyc(20);
        key_l_n = 1'b1;
        cyc(20);

        // Simultaneous presses.
        key_l_n = 1'b0;
        key_r_n = 1'b0;
        cyc(20);
        key_l_n = 1'b1;
        key_r_n = 1'b1;
        cyc(20);

        // Reset in the middle of a count with the key still held.
        key_l_n = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(20);
        key_l_n = 1'b1;
        cyc(20);

        // Random activity: short and long runs on each key, rare resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) key_l_n = ~key_l_n;
            if ($urandom_range(0, 5) == 0) key_r_n = ~key_r_n;
            reset = ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0;
            cyc(1);
        end
        reset   = 1'b0;
        key_l_n = 1'b1;
        key_r_n = 1'b1;
        cyc(15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/key_press_conditioner.md
Name: key_press_conditioner

Overview:
Input front end for the tug-of-war playfield. Takes the two raw, active-low, asynchronous push-button inputs (left and right player keys). Synchronises, debounces and edge-detects each one. Produces single-cycle press pulses that drive the L/R inputs of every playfield light cell. One press yields exactly one pulse regardless of how long the key is held.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronised level must be stable before it is accepted; 20 ms at 50 MHz; must be >= 1; benches override to 4.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
key_l_n  in  1  raw left key, 0 = pressed, asynchronous to clk
key_r_n  in  1  raw right key, 0 = pressed, asynchronous to clk
l_press  out  1  one-cycle pulse on accepted left press (feeds L)
r_press  out  1  one-cycle pulse on accepted right press (feeds R)
l_held  out  1  debounced left level, 1 = pressed
r_held  out  1  debounced right level, 1 = pressed

Behaviour:
- Reset: clk is the only clock; reset is synchronous, active-high.
  - Per channel on reset: both sync FFs = 1 (released), debounced state = released, counter = 0.
  - All outputs are 0 during reset and in the first cycle after it.
- Channels are fully independent. The left and right paths are identical, with no cross-coupling.
- Synchroniser: 2-FF chain on the raw input; sync2 is the only signal used downstream.
- Debounce counter:
  - Width is $clog2(DEBOUNCE_CYCLES+1).
  - While sync2 equals the debounced state, the counter clears to 0.
  - While sync2 differs and counter < DEBOUNCE_CYCLES-1, the counter increments.
  - While sync2 differs and counter == DEBOUNCE_CYCLES-1, the debounced state toggles and the counter clears.
- Per-channel states: RELEASED and PRESSED (debounced state). held = (state == PRESSED), registered.
- Press pulse:
  - Registered; high for exactly one cycle.
  - Asserted at the same edge where the state goes RELEASED -> PRESSED.
  - The PRESSED -> RELEASED transition never pulses.
- Latency: let edge 0 be the first clk edge that samples the raw input low, with the input held low thereafter. Then press and held go high after edge DEBOUNCE_CYCLES+1.
  - Release latency is identical, measured to held falling.
- Glitch rejection: any excursion of sync2 shorter than DEBOUNCE_CYCLES cycles clears the counter. The state is unchanged and no pulse occurs.
- Hold: a key held indefinitely gives one pulse; held stays 1.
- Simultaneous presses: both pulses may assert in the same cycle. This is legal; the playfield treats L&R as no move.
- Reset mid-count: the counter and state are discarded.
- Key held through reset: it is seen as a fresh press after reset deasserts, giving one pulse at the normal latency counted from the first post-reset sample.
- Counter must never wrap. Its value is bounded by DEBOUNCE_CYCLES-1.

Decomposition:
- Shared package tug_pkg:
  - KEY_ACTIVE_LEVEL = 1'b0
  - DEFAULT_DEBOUNCE_CYCLES = 1000000
  - key_state_t enum {KEY_RELEASED, KEY_PRESSED}, which is reused by later scoring logic.
- One sub-module, key_debounce_channel:
  - Contains the synchroniser, counter, state register and pulse register.
  - Ports: clk, reset, key_n, press, held; parameter DEBOUNCE_CYCLES.
  - Instantiated twice in key_press_conditioner. The top level contains no other logic.

Test Plan (DEBOUNCE_CYCLES = 4):
- Reset, inputs idle high for 10 cycles -> l_press, r_press, l_held, r_held all 0 throughout.
- key_l_n driven 0 and held 20 cycles -> l_press is 1 for exactly the one cycle after edge 5 (edge 0 = first low sample); l_held is 1 from then on; r_* stay 0.
- key_r_n low for 2 cycles, then high -> no r_press, r_held stays 0. Repeat with 3 cycles low -> same result.
- Release after a held press: key_l_n back to 1 -> l_held falls after edge 5 of release; no pulse. A second press 10 cycles later -> a second single l_press pulse.
- Both keys driven low on the same edge -> l_press and r_press are both 1 in the same single cycle.
- Reset asserted 2 cycles after key_l_n goes low, held 3 cycles, key still low:
  - No pulse during reset.
  - After reset deasserts, exactly one l_press at latency 5 from the first post-reset sample.
